// File: rtl/nios_system_cpu_debug_ocimem_ctrl.sv
// nios_system_cpu_debug_ocimem_ctrl: debug RAM + monitor flags shared by JTAG strobes and a CPU Avalon slave.
// JTAG strobes win arbitration; the CPU is held off through waitrequest.
module nios_system_cpu_debug_ocimem_ctrl #(
    parameter int RAM_ADDR_W = 8,
    parameter     RAM_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [37:0]           jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic                  take_no_action_ocimem_a,
    input  logic [RAM_ADDR_W:0]   address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [3:0]            byteenable,
    input  logic [31:0]           writedata,
    input  logic                  debugaccess,
    output logic [31:0]           readdata,
    output logic                  waitrequest,
    output logic [31:0]           MonDReg,
    output logic [RAM_ADDR_W-1:0] MonAReg,
    output logic                  monitor_ready,
    output logic                  monitor_error
);
    typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;
    state_t r_state;
    (* ram_init_file = RAM_INIT_FILE *) logic [31:0] r_mem [2**RAM_ADDR_W];
    logic [31:0] r_q, r_mond, r_rdata;
    logic [RAM_ADDR_W-1:0] r_mona, w_addr;
    logic r_rdy, r_err;
    logic w_idle, w_strobe, w_do_a, w_do_b, w_do_n, w_cpu_rd, w_cpu_wr, w_cpu_go, w_reg0, w_we;
    logic [31:0] w_wd;
    logic [3:0] w_be;
    logic w_unused;
    assign w_unused = &{1'b0, jdo[37:35], jdo[2:0]};
    assign w_idle   = r_state == IDLE;
    assign w_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_do_b   = w_idle & take_action_ocimem_b;
    assign w_do_a   = w_idle & take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_do_n   = w_idle & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_cpu_rd = chipselect & read;
    assign w_cpu_wr = chipselect & write & ~read;
    assign w_cpu_go = w_idle & ~w_strobe;
    assign w_reg0   = address[RAM_ADDR_W] & (address[RAM_ADDR_W-1:0] == '0);
    // Single RAM port: JTAG owns it on a strobe, otherwise the CPU address drives it
    assign w_addr = (w_do_b | w_do_n) ? r_mona : w_do_a ? jdo[26 +: RAM_ADDR_W] : address[RAM_ADDR_W-1:0];
    assign w_we   = w_do_b | (w_cpu_go & w_cpu_wr & ~address[RAM_ADDR_W] & debugaccess);
    assign w_be   = w_do_b ? 4'hf : byteenable;
    assign w_wd   = w_do_b ? jdo[34:3] : writedata;
    assign waitrequest   = (w_cpu_rd | w_cpu_wr) & (r_state == JRD | (w_idle & (w_strobe | w_cpu_rd)));
    assign readdata      = r_rdata;
    assign MonDReg       = r_mond;
    assign MonAReg       = r_mona;
    assign monitor_ready = r_rdy;
    assign monitor_error = r_err;
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (w_we && w_be[i]) r_mem[w_addr][8*i +: 8] <= w_wd[8*i +: 8];
        r_q <= r_mem[w_addr];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mona  <= '0;
            r_mond  <= '0;
            r_rdata <= '0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_do_b) begin
                        r_mond <= jdo[34:3];
                        r_mona <= r_mona + RAM_ADDR_W'(1);
                    end else if (w_do_a) begin
                        r_mona <= jdo[26 +: RAM_ADDR_W];
                        if (jdo[17]) begin
                            r_rdy <= 1'b0;
                            r_err <= 1'b0;
                        end
                        if (jdo[34]) r_state <= JRD;
                    end else if (w_do_n) begin
                        r_state <= JRD;
                    end else if (w_cpu_rd) begin
                        r_state <= CRD;
                    end else if (w_cpu_wr && w_reg0) begin
                        r_rdy <= r_rdy | writedata[0];
                        r_err <= r_err | writedata[1];
                    end
                end
                JRD: begin
                    r_mond  <= r_q;
                    r_mona  <= r_mona + RAM_ADDR_W'(1);
                    r_state <= IDLE;
                end
                default: begin
                    r_rdata <= address[RAM_ADDR_W] ? {30'b0, r_err & w_reg0, r_rdy & w_reg0} : r_q;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nios_system_cpu_debug_ocimem_ctrl.sv
// tb_nios_system_cpu_debug_ocimem_ctrl: per-cycle vector table with hand-computed expectations.
module tb_nios_system_cpu_debug_ocimem_ctrl;
    logic        clk = 0, reset = 1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 0, take_action_ocimem_b = 0, take_no_action_ocimem_a = 0;
    logic [8:0]  address = '0;
    logic        chipselect = 0, read = 0, write = 0, debugaccess = 0;
    logic [3:0]  byteenable = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, MonDReg;
    logic [7:0]  MonAReg;
    logic        waitrequest, monitor_ready, monitor_error;
    int checks = 0, failures = 0, since = 100;

    nios_system_cpu_debug_ocimem_ctrl #(.RAM_ADDR_W(8), .RAM_INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .debugaccess(debugaccess),
        .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg), .MonAReg(MonAReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    // Upstream synchroniser guarantees strobes at least 3 clocks apart
    always @(posedge clk) begin
        if (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a) begin
            assert (since >= 3) else $error("strobe spacing violated: %0d", since);
            since <= 1;
        end else since <= since + 1;
    end

    typedef struct {
        logic rst, sa, sb, sn;
        logic [37:0] jdo;
        logic cs, rd, wr, dbg;
        logic [3:0] be;
        logic [8:0] addr;
        logic [31:0] wd;
        logic e_wait;
        logic [7:0] e_mona;
        logic [31:0] e_mond;
        logic e_rdy, e_err;
        logic [31:0] e_rdata;
    } vec_t;
    vec_t vq[$];

    task automatic v(input logic rst, sa, sb, sn, input logic [37:0] j, input logic cs, rd, wr, dbg,
                     input logic [3:0] be, input logic [8:0] a, input logic [31:0] wd, input logic ew,
                     input logic [7:0] em, input logic [31:0] ed, input logic er, ee, input logic [31:0] erd);
        vq.push_back('{rst, sa, sb, sn, j, cs, rd, wr, dbg, be, a, wd, ew, em, ed, er, ee, erd});
    endtask
    task automatic jt(input logic sa, sb, sn, input logic [37:0] j, input logic [7:0] em,
                      input logic [31:0] ed, input logic er, ee, input logic [31:0] erd);
        v(0, sa, sb, sn, j, 0, 0, 0, 0, 0, 0, 0, 0, em, ed, er, ee, erd);
    endtask
    task automatic cp(input logic rd, wr, dbg, input logic [3:0] be, input logic [8:0] a, input logic [31:0] wd,
                      input logic ew, input logic [7:0] em, input logic [31:0] ed, input logic er, ee,
                      input logic [31:0] erd);
        v(0, 0, 0, 0, 0, 1, rd, wr, dbg, be, a, wd, ew, em, ed, er, ee, erd);
    endtask
    task automatic idle(input int n, input logic [7:0] em, input logic [31:0] ed, input logic er, ee,
                        input logic [31:0] erd);
        for (int k = 0; k < n; k++) jt(0, 0, 0, 0, em, ed, er, ee, erd);
    endtask
    function automatic logic [37:0] ja(input logic [7:0] a, input logic rd, clr);
        ja = '0;
        ja[33:26] = a;
        ja[34] = rd;
        ja[17] = clr;
    endfunction
    function automatic logic [37:0] jb(input logic [31:0] d);
        jb = '0;
        jb[34:3] = d;
    endfunction
    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 32'h0);
        // JTAG writes, reads back, streaming read
        jt(0, 1, 0, jb(32'hDEADBEEF), 8'h01, 32'hDEADBEEF, 0, 0, 0);
        idle(2, 8'h01, 32'hDEADBEEF, 0, 0, 0);
        jt(0, 1, 0, jb(32'h12345678), 8'h02, 32'h12345678, 0, 0, 0);
        idle(2, 8'h02, 32'h12345678, 0, 0, 0);
        jt(1, 0, 0, ja(8'h00, 1, 0), 8'h00, 32'h12345678, 0, 0, 0);
        idle(2, 8'h01, 32'hDEADBEEF, 0, 0, 0);
        jt(0, 0, 1, 0, 8'h01, 32'hDEADBEEF, 0, 0, 0);
        idle(2, 8'h02, 32'h12345678, 0, 0, 0);
        // Address wrap on writes and reads
        jt(1, 0, 0, ja(8'hFF, 0, 0), 8'hFF, 32'h12345678, 0, 0, 0);
        idle(2, 8'hFF, 32'h12345678, 0, 0, 0);
        jt(0, 1, 0, jb(32'hCAFEF00D), 8'h00, 32'hCAFEF00D, 0, 0, 0);
        idle(2, 8'h00, 32'hCAFEF00D, 0, 0, 0);
        jt(0, 1, 0, jb(32'h0BADF00D), 8'h01, 32'h0BADF00D, 0, 0, 0);
        idle(2, 8'h01, 32'h0BADF00D, 0, 0, 0);
        jt(1, 0, 0, ja(8'hFF, 1, 0), 8'hFF, 32'h0BADF00D, 0, 0, 0);
        idle(2, 8'h00, 32'hCAFEF00D, 0, 0, 0);
        jt(0, 0, 1, 0, 8'h00, 32'hCAFEF00D, 0, 0, 0);
        idle(2, 8'h01, 32'h0BADF00D, 0, 0, 0);
        // CPU flag writes (sticky), register read, JTAG clear
        cp(0, 1, 0, 4'hF, 9'h100, 32'h1, 0, 8'h01, 32'h0BADF00D, 1, 0, 0);
        cp(0, 1, 0, 4'hF, 9'h100, 32'h2, 0, 8'h01, 32'h0BADF00D, 1, 1, 0);
        cp(0, 1, 0, 4'hF, 9'h100, 32'h0, 0, 8'h01, 32'h0BADF00D, 1, 1, 0);
        cp(1, 0, 0, 4'hF, 9'h100, 32'h0, 1, 8'h01, 32'h0BADF00D, 1, 1, 0);
        cp(1, 0, 0, 4'hF, 9'h100, 32'h0, 0, 8'h01, 32'h0BADF00D, 1, 1, 32'h3);
        idle(1, 8'h01, 32'h0BADF00D, 1, 1, 32'h3);
        jt(1, 0, 0, ja(8'h10, 0, 1), 8'h10, 32'h0BADF00D, 0, 0, 32'h3);
        idle(2, 8'h10, 32'h0BADF00D, 0, 0, 32'h3);
        // Non-zero register address: writes ignored, reads zero
        cp(0, 1, 0, 4'hF, 9'h101, 32'h3, 0, 8'h10, 32'h0BADF00D, 0, 0, 32'h3);
        cp(1, 0, 0, 4'hF, 9'h101, 32'h0, 1, 8'h10, 32'h0BADF00D, 0, 0, 32'h3);
        cp(1, 0, 0, 4'hF, 9'h101, 32'h0, 0, 8'h10, 32'h0BADF00D, 0, 0, 32'h0);
        idle(1, 8'h10, 32'h0BADF00D, 0, 0, 0);
        // CPU RAM writes: debugaccess gate and byte lanes
        jt(1, 0, 0, ja(8'h05, 0, 0), 8'h05, 32'h0BADF00D, 0, 0, 0);
        idle(2, 8'h05, 32'h0BADF00D, 0, 0, 0);
        jt(0, 1, 0, jb(32'h11223344), 8'h06, 32'h11223344, 0, 0, 0);
        idle(1, 8'h06, 32'h11223344, 0, 0, 0);
        cp(0, 1, 0, 4'hF, 9'h005, 32'hFFFFFFFF, 0, 8'h06, 32'h11223344, 0, 0, 0);
        cp(1, 0, 0, 4'hF, 9'h005, 32'h0, 1, 8'h06, 32'h11223344, 0, 0, 0);
        cp(1, 0, 0, 4'hF, 9'h005, 32'h0, 0, 8'h06, 32'h11223344, 0, 0, 32'h11223344);
        cp(0, 1, 1, 4'b0010, 9'h005, 32'h0000AB00, 0, 8'h06, 32'h11223344, 0, 0, 32'h11223344);
        cp(1, 0, 0, 4'hF, 9'h005, 32'h0, 1, 8'h06, 32'h11223344, 0, 0, 32'h11223344);
        cp(1, 0, 0, 4'hF, 9'h005, 32'h0, 0, 8'h06, 32'h11223344, 0, 0, 32'h1122AB44);
        idle(1, 8'h06, 32'h11223344, 0, 0, 32'h1122AB44);
        // CPU read colliding with a JTAG write to the same word
        jt(1, 0, 0, ja(8'h05, 0, 0), 8'h05, 32'h11223344, 0, 0, 32'h1122AB44);
        idle(2, 8'h05, 32'h11223344, 0, 0, 32'h1122AB44);
        v(0, 0, 1, 0, jb(32'hA5A5A5A5), 1, 1, 0, 0, 4'hF, 9'h005, 0, 1, 8'h06, 32'hA5A5A5A5, 0, 0, 32'h1122AB44);
        cp(1, 0, 0, 4'hF, 9'h005, 32'h0, 1, 8'h06, 32'hA5A5A5A5, 0, 0, 32'h1122AB44);
        cp(1, 0, 0, 4'hF, 9'h005, 32'h0, 0, 8'h06, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5);
        idle(1, 8'h06, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5);
        // CPU register write held through a JTAG read
        v(0, 1, 0, 0, ja(8'h00, 1, 0), 1, 0, 1, 0, 4'hF, 9'h100, 32'h1, 1, 8'h00, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5);
        cp(0, 1, 0, 4'hF, 9'h100, 32'h1, 1, 8'h01, 32'h0BADF00D, 0, 0, 32'hA5A5A5A5);
        cp(0, 1, 0, 4'hF, 9'h100, 32'h1, 0, 8'h01, 32'h0BADF00D, 1, 0, 32'hA5A5A5A5);
        idle(1, 8'h01, 32'h0BADF00D, 1, 0, 32'hA5A5A5A5);
        // Reset during CRD, RAM survives reset
        cp(1, 0, 0, 4'hF, 9'h005, 32'h0, 1, 8'h01, 32'h0BADF00D, 1, 0, 32'hA5A5A5A5);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 32'h0);
        idle(1, 8'h00, 32'h0, 0, 0, 0);
        jt(0, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0);
        idle(2, 8'h01, 32'h0BADF00D, 0, 0, 0);
        // Strobe priority: b beats a
        jt(1, 1, 0, jb(32'h80004000), 8'h02, 32'h80004000, 0, 0, 0);
        idle(2, 8'h02, 32'h80004000, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst;
            take_action_ocimem_a = vq[i].sa;
            take_action_ocimem_b = vq[i].sb;
            take_no_action_ocimem_a = vq[i].sn;
            jdo = vq[i].jdo;
            chipselect = vq[i].cs;
            read = vq[i].rd;
            write = vq[i].wr;
            debugaccess = vq[i].dbg;
            byteenable = vq[i].be;
            address = vq[i].addr;
            writedata = vq[i].wd;
            #1;
            chk("waitrequest", i, 32'(waitrequest), 32'(vq[i].e_wait));
            @(posedge clk);
            #1;
            chk("MonAReg", i, 32'(MonAReg), 32'(vq[i].e_mona));
            chk("MonDReg", i, MonDReg, vq[i].e_mond);
            chk("monitor_ready", i, 32'(monitor_ready), 32'(vq[i].e_rdy));
            chk("monitor_error", i, 32'(monitor_error), 32'(vq[i].e_err));
            chk("readdata", i, readdata, vq[i].e_rdata);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
